// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle controller for unsigned multiply (op 0010)
// and divide (op 0011) beside the single-cycle EX-stage ALU. It stalls the
// pipeline while an iterative shift-add multiply or restoring divide runs,
// then presents the result with a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam logic [3:0]       OP_MUL = 4'b0010;
  localparam logic [3:0]       OP_DIV = 4'b0011;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] prodNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quotNext;
  logic               isRequest;

  // One iteration of each algorithm. opnd_q holds the multiplicand for MUL
  // and the divisor for DIV. The multiplier sits in the low half of prod_q
  // and is consumed one bit per step as the accumulator shifts right.
  always_comb begin
    mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    prodNext = {mulSum, prod_q[WIDTH-1:1]};
    divShift = {rem_q, quot_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, opnd_q};
    if (divDiff[WIDTH]) begin
      remNext  = divShift[WIDTH-1:0];
      quotNext = {quot_q[WIDTH-2:0], 1'b0};
    end else begin
      remNext  = divDiff[WIDTH-1:0];
      quotNext = {quot_q[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state and datapath control; flush outranks start and aborts a
  // running operation without touching the held results.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    res_d     = res_q;
    hi_d      = hi_q;
    dbz_d     = dbz_q;
    isRequest = start && !flush && (operation == OP_MUL || operation == OP_DIV);
    case (state_q)
      IDLE: begin
        if (isRequest && operation == OP_MUL) begin
          opnd_d  = operand_a;
          prod_d  = {{WIDTH{1'b0}}, operand_b};
          cnt_d   = '0;
          state_d = MUL;
        end else if (isRequest && operand_b != '0) begin
          opnd_d  = operand_b;
          quot_d  = operand_a;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end else if (isRequest) begin
          res_d   = '1;
          hi_d    = operand_a;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          prod_d = prodNext;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            res_d   = prodNext[WIDTH-1:0];
            hi_d    = prodNext[2*WIDTH-1:WIDTH];
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DIV: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          quot_d = quotNext;
          rem_d  = remNext;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            res_d   = quotNext;
            hi_d    = remNext;
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: begin
        dbz_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
    end
  end

  assign stall       = (state_q == IDLE && isRequest) || state_q == MUL || state_q == DIV;
  assign done        = (state_q == DONE);
  assign result      = res_q;
  assign result_hi   = hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed bench for muldiv_sequencer with a scoreboard
// of expected results pushed at request time and popped at done.
module tb_muldiv_sequencer;

  localparam int W = 16;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   operation;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         flush;
  logic         stall;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  exp_t sbq[$];
  exp_t expItem;
  int   vectors    = 0;
  int   miscompares = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall(stall), .done(done), .result(result), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request on the next falling edge and push its reference result.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    operation = op;
    operand_a = a;
    operand_b = b;
    if (op == OP_MUL) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e = '{res: p[W-1:0], hi: p[2*W-1:W], dbz: 1'b0};
    end else if (b == '0) begin
      e = '{res: {W{1'b1}}, hi: a, dbz: 1'b1};
    end else begin
      e = '{res: a / b, hi: a % b, dbz: 1'b0};
    end
    sbq.push_back(e);
  endtask

  // Walk the request cycle by cycle: stall must hold for `latency` cycles,
  // then done pulses and the scoreboard head is compared.
  task automatic runToDone(input int latency, input string tag);
    for (int c = 0; c <= latency; c++) begin
      #1;
      if (c < latency) begin
        checkOutput({tag, "_stall"}, 32'(stall), 32'd1);
        checkOutput({tag, "_early_done"}, 32'(done), 32'd0);
        @(negedge clk);
      end else begin
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_stall_in_done"}, 32'(stall), 32'd0);
        checkOutput({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          expItem = sbq.pop_front();
          checkOutput({tag, "_result"}, 32'(result), 32'(expItem.res));
          checkOutput({tag, "_result_hi"}, 32'(result_hi), 32'(expItem.hi));
          checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(expItem.dbz));
        end
      end
    end
  endtask

  // Hold current inputs for n cycles and confirm the block stays quiet.
  task automatic idleCycles(input int n, input logic [W-1:0] er, input logic [W-1:0] eh, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
      checkOutput({tag, "_result"}, 32'(result), 32'(er));
      checkOutput({tag, "_result_hi"}, 32'(result_hi), 32'(eh));
    end
  endtask

  // Directed sequence of all scenarios.
  initial begin
    rst = 1'b1; start = 1'b0; operation = 4'b0000;
    operand_a = '0; operand_b = '0; flush = 1'b0;
    #1;
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_result_hi", 32'(result_hi), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Multiplies
    applyStimulus(OP_MUL, 16'd7, 16'd6);
    runToDone(W + 1, "mul_7x6");
    start = 1'b0;
    idleCycles(2, 16'h002A, 16'h0000, "mul_7x6_hold");

    applyStimulus(OP_MUL, 16'hFFFF, 16'hFFFF);
    runToDone(W + 1, "mul_full");
    start = 1'b0;
    idleCycles(1, 16'h0001, 16'hFFFE, "mul_full_hold");

    // Divides, second one back-to-back after DONE
    applyStimulus(OP_DIV, 16'd100, 16'd7);
    runToDone(W + 1, "div_100_7");
    applyStimulus(OP_DIV, 16'hFFFF, 16'h0001);
    runToDone(W + 1, "div_ffff_1");
    start = 1'b0;
    idleCycles(1, 16'hFFFF, 16'h0000, "div_b2b_hold");

    // Divide by zero
    applyStimulus(OP_DIV, 16'h1234, 16'h0000);
    runToDone(1, "div_zero");
    start = 1'b0;
    idleCycles(2, 16'hFFFF, 16'h1234, "div_zero_clear");

    // Non mul/div codes are ignored
    @(negedge clk);
    start = 1'b1; operation = 4'b0000; operand_a = 16'h5555; operand_b = 16'h0003;
    idleCycles(3, 16'hFFFF, 16'h1234, "op_0000");
    operation = 4'b1000;
    idleCycles(3, 16'hFFFF, 16'h1234, "op_1000");

    // Flush in IDLE blocks a valid request
    operation = OP_MUL; flush = 1'b1;
    #1;
    checkOutput("flush_idle_stall", 32'(stall), 32'd0);
    idleCycles(2, 16'hFFFF, 16'h1234, "flush_idle");
    flush = 1'b0; start = 1'b0;

    // Flush at T+5 of a MUL: back to IDLE, no done, results retained
    applyStimulus(OP_MUL, 16'd3, 16'd5);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("flush_mul_stall", 32'(stall), 32'd1);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    checkOutput("flush_mul_stall_t5", 32'(stall), 32'd1);
    void'(sbq.pop_front());
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    checkOutput("flush_mul_t6_stall", 32'(stall), 32'd0);
    checkOutput("flush_mul_t6_done", 32'(done), 32'd0);
    idleCycles(20, 16'hFFFF, 16'h1234, "flush_mul_quiet");
    applyStimulus(OP_MUL, 16'd3, 16'd5);
    runToDone(W + 1, "mul_after_flush");
    start = 1'b0;

    // Asynchronous reset in the middle of a divide
    applyStimulus(OP_DIV, 16'h9999, 16'h0003);
    for (int c = 0; c < 4; c++) @(negedge clk);
    #2;
    start = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_result", 32'(result), 32'd0);
    checkOutput("rst_mid_result_hi", 32'(result_hi), 32'd0);
    checkOutput("rst_mid_done", 32'(done), 32'd0);
    checkOutput("rst_mid_dbz", 32'(div_by_zero), 32'd0);
    checkOutput("rst_mid_stall", 32'(stall), 32'd0);
    void'(sbq.pop_front());
    @(negedge clk);
    rst = 1'b0;
    idleCycles(3, 16'h0000, 16'h0000, "rst_mid_idle");
    applyStimulus(OP_DIV, 16'h9999, 16'h0003);
    runToDone(W + 1, "div_after_rst");
    start = 1'b0;

    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
